wc_pad_serdes: RTL and testbench



---
 rtl/wc_io_pkg.sv | 20 ++
 rtl/wc_pad_ser.sv | 60 ++++++
 rtl/wc_pad_serdes.sv | 118 +++++++++++
 tb/tb_wc_pad_serdes.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wc_io_pkg.sv
// Shared definitions for the Winograd-core pad bridge: default widths, FSM states and the
// ceil-divide used to size the pad beat counts.
package wc_io_pkg;

  localparam int unsigned DefCoreInW  = 70;
  localparam int unsigned DefCoreOutW = 50;
  localparam int unsigned DefPadInW   = 10;
  localparam int unsigned DefPadOutW  = 10;

  typedef enum logic [1:0] {
    StLoad,
    StWait,
    StDrain
  } state_e;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/wc_pad_ser.sv
// Output serializer: loads one core result and shifts it out LSB beat first on the pad bus,
// holding the current beat stable while the sink stalls.
module wc_pad_ser
  import wc_io_pkg::*;
#(
  parameter int unsigned CORE_OUT_W = DefCoreOutW,
  parameter int unsigned PAD_OUT_W  = DefPadOutW,
  parameter int unsigned OUT_BEATS  = ceil_div(CORE_OUT_W, PAD_OUT_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [CORE_OUT_W-1:0] data,
  input  logic                  rdy,
  output logic [PAD_OUT_W-1:0]  pad_z,
  output logic                  vld,
  output logic                  last,
  output logic                  done
);

  localparam int unsigned ShW = OUT_BEATS * PAD_OUT_W;
  localparam int unsigned CntW = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;

  logic [ShW-1:0]  sh_q;
  logic [CntW-1:0] cnt_q;
  logic            vld_q;
  logic            last_q;
  logic            adv;

  assign adv   = vld_q && rdy;
  assign done  = adv && last_q;
  assign pad_z = sh_q[PAD_OUT_W-1:0];
  assign vld   = vld_q;
  assign last  = last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else if (load) begin
      // Zero-extension leaves the unused top bits of the final beat at 0.
      sh_q   <= ShW'(data);
      cnt_q  <= '0;
      vld_q  <= 1'b1;
      last_q <= (OUT_BEATS == 1);
    end else if (done) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else if (adv) begin
      sh_q   <= sh_q >> PAD_OUT_W;
      cnt_q  <= cnt_q + 1'b1;
      last_q <= (int'(cnt_q) == int'(OUT_BEATS) - 2);
    end
  end

endmodule

// File: rtl/wc_pad_serdes.sv
// Pad-limited IO bridge: assembles narrow input beats into one core word, strobes it to the
// core, waits the core latency, then serializes the core result onto the output pads.
module wc_pad_serdes
  import wc_io_pkg::*;
#(
  parameter int unsigned CORE_IN_W  = DefCoreInW,
  parameter int unsigned CORE_OUT_W = DefCoreOutW,
  parameter int unsigned PAD_IN_W   = DefPadInW,
  parameter int unsigned PAD_OUT_W  = DefPadOutW,
  parameter int unsigned CORE_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PAD_IN_W-1:0]   pad_d,
  input  logic                  pad_d_vld,
  input  logic                  pad_d_sof,
  output logic                  pad_d_rdy,
  output logic [CORE_IN_W-1:0]  core_d,
  output logic                  core_d_vld,
  input  logic [CORE_OUT_W-1:0] core_z,
  output logic [PAD_OUT_W-1:0]  pad_z,
  output logic                  pad_z_vld,
  output logic                  pad_z_last,
  input  logic                  pad_z_rdy
);

  localparam int unsigned InBeats  = ceil_div(CORE_IN_W, PAD_IN_W);
  localparam int unsigned OutBeats = ceil_div(CORE_OUT_W, PAD_OUT_W);
  localparam int unsigned AsmW     = InBeats * PAD_IN_W;
  localparam int unsigned InCntW   = (InBeats > 1) ? $clog2(InBeats) : 1;
  localparam int unsigned LatCntW  = $clog2(CORE_LAT + 1);

  state_e             state_q;
  logic [InCntW-1:0]  in_cnt_q;
  logic [InCntW-1:0]  beat_idx;
  logic [LatCntW-1:0] lat_cnt_q;
  logic [AsmW-1:0]    asm_q;
  logic [AsmW-1:0]    asm_d;
  logic               accept;
  logic               last_in;
  logic               ser_load;
  logic               ser_done;

  assign pad_d_rdy = (state_q == StLoad);
  assign accept    = pad_d_vld && pad_d_rdy;
  // An accepted sof beat restarts assembly at beat 0, dropping any partial frame.
  assign beat_idx  = pad_d_sof ? '0 : in_cnt_q;
  assign last_in   = (beat_idx == InCntW'(InBeats - 1));
  assign ser_load  = (state_q == StWait) && (lat_cnt_q == LatCntW'(CORE_LAT));

  always_comb begin
    asm_d = asm_q;
    for (int unsigned b = 0; b < InBeats; b++) begin
      if (beat_idx == InCntW'(b)) begin
        asm_d[b*PAD_IN_W +: PAD_IN_W] = pad_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StLoad;
      in_cnt_q   <= '0;
      lat_cnt_q  <= '0;
      asm_q      <= '0;
      core_d     <= '0;
      core_d_vld <= 1'b0;
    end else begin
      core_d_vld <= 1'b0;
      unique case (state_q)
        StLoad: begin
          if (accept) begin
            asm_q <= asm_d;
            if (last_in) begin
              core_d     <= asm_d[CORE_IN_W-1:0];
              core_d_vld <= 1'b1;
              in_cnt_q   <= '0;
              state_q    <= StWait;
            end else begin
              in_cnt_q <= beat_idx + 1'b1;
            end
          end
        end
        StWait: begin
          if (ser_load) begin
            lat_cnt_q <= '0;
            state_q   <= StDrain;
          end else begin
            lat_cnt_q <= lat_cnt_q + 1'b1;
          end
        end
        StDrain: begin
          if (ser_done) begin
            state_q <= StLoad;
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  wc_pad_ser #(
    .CORE_OUT_W(CORE_OUT_W),
    .PAD_OUT_W (PAD_OUT_W),
    .OUT_BEATS (OutBeats)
  ) u_ser (
    .clk  (clk),
    .rst  (rst),
    .load (ser_load),
    .data (core_z),
    .rdy  (pad_z_rdy),
    .pad_z(pad_z),
    .vld  (pad_z_vld),
    .last (pad_z_last),
    .done (ser_done)
  );

endmodule

// File: tb/tb_wc_pad_serdes.sv
// Bench for wc_pad_serdes: table-driven frames, hand-written corner sequences, randomized
// frames against a reference core model, plus a second instance with wider input pads.
module tb_wc_pad_serdes;

  localparam int CIW  = 70;
  localparam int COW  = 50;
  localparam int PIW  = 10;
  localparam int POW  = 10;
  localparam int LAT  = 1;
  localparam int INB  = 7;
  localparam int OUTB = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [PIW-1:0]  pad_d;
  logic            pad_d_vld, pad_d_sof, pad_d_rdy;
  logic [CIW-1:0]  core_d;
  logic            core_d_vld;
  logic [COW-1:0]  core_z;
  logic [POW-1:0]  pad_z;
  logic            pad_z_vld, pad_z_last, pad_z_rdy;

  logic [15:0]     pad_d1;
  logic            pad_d_vld1, pad_d_sof1, pad_d_rdy1;
  logic [CIW-1:0]  core_d1;
  logic            core_d_vld1;
  logic [COW-1:0]  core_z1;
  logic [POW-1:0]  pad_z1;
  logic            pad_z_vld1, pad_z_last1, pad_z_rdy1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wc_pad_serdes #(
    .CORE_IN_W(CIW), .CORE_OUT_W(COW), .PAD_IN_W(PIW), .PAD_OUT_W(POW), .CORE_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .pad_d(pad_d), .pad_d_vld(pad_d_vld), .pad_d_sof(pad_d_sof),
    .pad_d_rdy(pad_d_rdy), .core_d(core_d), .core_d_vld(core_d_vld), .core_z(core_z),
    .pad_z(pad_z), .pad_z_vld(pad_z_vld), .pad_z_last(pad_z_last), .pad_z_rdy(pad_z_rdy)
  );

  wc_pad_serdes #(
    .CORE_IN_W(70), .CORE_OUT_W(50), .PAD_IN_W(16), .PAD_OUT_W(10), .CORE_LAT(3)
  ) dut1 (
    .clk(clk), .rst(rst), .pad_d(pad_d1), .pad_d_vld(pad_d_vld1), .pad_d_sof(pad_d_sof1),
    .pad_d_rdy(pad_d_rdy1), .core_d(core_d1), .core_d_vld(core_d_vld1), .core_z(core_z1),
    .pad_z(pad_z1), .pad_z_vld(pad_z_vld1), .pad_z_last(pad_z_last1), .pad_z_rdy(pad_z_rdy1)
  );

  // Reference core: result is valid only in the single cycle CORE_LAT after the strobe,
  // random garbage otherwise, so a mistimed capture shows up as wrong output beats.
  logic           fixed_mode;
  logic [COW-1:0] fixed_z;
  logic [COW-1:0] zhold;
  logic [COW-1:0] garbage;
  int unsigned    zcnt = 0;
  int unsigned    vld_cnt = 0;

  function automatic logic [COW-1:0] core_fn(input logic [CIW-1:0] d);
    return d[49:0] ^ d[69:20];
  endfunction

  always @(posedge clk) begin
    garbage <= 50'({$urandom, $urandom});
    if (core_d_vld === 1'b1) begin
      vld_cnt <= vld_cnt + 1;
      zcnt    <= LAT;
      zhold   <= fixed_mode ? fixed_z : core_fn(core_d);
    end else if (zcnt > 0) begin
      zcnt <= zcnt - 1;
    end
  end

  assign core_z  = (zcnt == 1) ? zhold : garbage;
  assign core_z1 = 50'h1_2345_6789_ABCD;

  typedef struct {
    logic [6:0][9:0] b;
    int              junk;
    logic [69:0]     exp_d;
    logic [49:0]     z;
    logic [4:0][9:0] eb;
  } vec_t;

  vec_t tbl[4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_beat(input logic [9:0] d, input logic sof, input int gap);
    int budget = 100;
    for (int g = 0; g < gap; g++) begin
      pad_d_vld = 1'b0;
      pad_d_sof = 1'($urandom_range(0, 1));
      pad_d     = 10'($urandom);
      step();
    end
    pad_d     = d;
    pad_d_sof = sof;
    pad_d_vld = 1'b1;
    while (!pad_d_rdy && budget > 0) begin
      step();
      budget--;
    end
    check("pad_d_rdy_wait", 70'(pad_d_rdy), 70'(1));
    step();
    pad_d_vld = 1'b0;
    pad_d_sof = 1'b0;
  endtask

  task automatic collect(input logic [4:0][9:0] eb, input bit rrdy);
    int j = 0;
    int budget = 60;
    while (j < OUTB && budget > 0) begin
      budget--;
      pad_z_rdy = rrdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      check("pad_z_vld", 70'(pad_z_vld), 70'(1));
      check("pad_z", 70'(pad_z), 70'(eb[j]));
      check("pad_z_last", 70'(pad_z_last), 70'(j == OUTB - 1));
      check("pad_d_rdy_drain", 70'(pad_d_rdy), 70'(0));
      if (pad_z_rdy) j++;
      step();
    end
    check("out_beats", 70'(j), 70'(OUTB));
    check("pad_z_vld_end", 70'(pad_z_vld), 70'(0));
    check("pad_z_end", 70'(pad_z), 70'(0));
    check("pad_d_rdy_end", 70'(pad_d_rdy), 70'(1));
  endtask

  task automatic run_frame(input logic [6:0][9:0] b, input int junk, input bit first_sof,
                           input bit rgap, input logic [69:0] exp_d, input logic [49:0] z,
                           input bit use_fixed, input logic [4:0][9:0] eb, input bit rrdy);
    int unsigned v0 = vld_cnt;
    fixed_mode = use_fixed;
    fixed_z    = z;
    for (int i = 0; i < junk; i++) begin
      send_beat(10'($urandom), (i == 0), rgap ? $urandom_range(0, 2) : 0);
    end
    for (int k = 0; k < INB; k++) begin
      send_beat(b[k], (k == 0) && first_sof, rgap ? $urandom_range(0, 2) : 0);
    end
    check("core_d_vld_t1", 70'(core_d_vld), 70'(1));
    check("core_d", core_d, exp_d);
    check("pad_d_rdy_wait_state", 70'(pad_d_rdy), 70'(0));
    // A held beat during WAIT/DRAIN must be ignored.
    pad_d     = 10'h3A5;
    pad_d_vld = 1'b1;
    pad_d_sof = 1'b1;
    step();
    check("core_d_vld_t2", 70'(core_d_vld), 70'(0));
    check("pad_z_vld_t2", 70'(pad_z_vld), 70'(0));
    step();
    collect(eb, rrdy);
    pad_d_vld = 1'b0;
    pad_d_sof = 1'b0;
    check("core_d_hold", core_d, exp_d);
    check("core_d_vld_pulses", 70'(vld_cnt - v0), 70'(1));
  endtask

  initial begin
    logic [6:0][9:0] rb;
    logic [69:0]     ed;
    logic [49:0]     ez;
    logic [4:0][9:0] reb;

    tbl[0] = '{{10'h007, 10'h006, 10'h005, 10'h004, 10'h003, 10'h002, 10'h001}, 0,
               {10'h007, 10'h006, 10'h005, 10'h004, 10'h003, 10'h002, 10'h001},
               {10'h005, 10'h004, 10'h003, 10'h002, 10'h001},
               {10'h005, 10'h004, 10'h003, 10'h002, 10'h001}};
    tbl[1] = '{{7{10'h3ff}}, 0, {70{1'b1}}, {50{1'b1}}, {5{10'h3ff}}};
    tbl[2] = '{{10'h155, 10'h2aa, 10'h155, 10'h2aa, 10'h155, 10'h2aa, 10'h155}, 3,
               {10'h155, 10'h2aa, 10'h155, 10'h2aa, 10'h155, 10'h2aa, 10'h155},
               {10'h2aa, 10'h155, 10'h2aa, 10'h155, 10'h2aa},
               {10'h2aa, 10'h155, 10'h2aa, 10'h155, 10'h2aa}};
    tbl[3] = '{{10'h200, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h001}, 2,
               70'h20_0000_0000_0000_0001, 50'h2_0000_0000_0001,
               {10'h200, 10'h000, 10'h000, 10'h000, 10'h001}};

    rst = 1'b1;
    pad_d = '0; pad_d_vld = 1'b0; pad_d_sof = 1'b0; pad_z_rdy = 1'b0;
    pad_d1 = '0; pad_d_vld1 = 1'b0; pad_d_sof1 = 1'b0; pad_z_rdy1 = 1'b0;
    fixed_mode = 1'b1;
    fixed_z = '0;
    repeat (3) step();
    rst = 1'b0;

    check("rst_core_d", core_d, 70'(0));
    check("rst_core_d_vld", 70'(core_d_vld), 70'(0));
    check("rst_pad_z", 70'(pad_z), 70'(0));
    check("rst_pad_z_vld", 70'(pad_z_vld), 70'(0));
    check("rst_pad_z_last", 70'(pad_z_last), 70'(0));
    check("rst_pad_d_rdy", 70'(pad_d_rdy), 70'(1));
    check("rst_pad_d_rdy1", 70'(pad_d_rdy1), 70'(1));

    for (int r = 0; r < 4; r++) begin
      run_frame(tbl[r].b, tbl[r].junk, 1'b1, 1'b0, tbl[r].exp_d, tbl[r].z, 1'b1, tbl[r].eb,
                1'b0);
    end

    // Backpressure: stall four cycles on output beat 2.
    fixed_mode = 1'b1;
    fixed_z = tbl[0].z;
    pad_z_rdy = 1'b1;
    for (int k = 0; k < INB; k++) send_beat(10'(k + 1), (k == 0), 0);
    step();
    step();
    for (int j = 0; j < 2; j++) begin
      check("bp_pre", 70'(pad_z), 70'(j + 1));
      step();
    end
    pad_z_rdy = 1'b0;
    repeat (4) begin
      check("bp_hold", 70'(pad_z), 70'(10'h003));
      check("bp_hold_vld", 70'(pad_z_vld), 70'(1));
      check("bp_hold_last", 70'(pad_z_last), 70'(0));
      step();
    end
    pad_z_rdy = 1'b1;
    for (int j = 2; j < OUTB; j++) begin
      check("bp_post", 70'(pad_z), 70'(j + 1));
      check("bp_post_last", 70'(pad_z_last), 70'(j == OUTB - 1));
      step();
    end
    check("bp_done", 70'(pad_z_vld), 70'(0));

    // Reset during output beat 3, then a frame without sof must assemble from beat 0.
    for (int k = 0; k < INB; k++) send_beat(10'(k + 1), (k == 0), 0);
    step();
    step();
    step();
    step();
    step();
    check("rd_beat3", 70'(pad_z), 70'(10'h004));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rd_pad_z_vld", 70'(pad_z_vld), 70'(0));
    check("rd_pad_z", 70'(pad_z), 70'(0));
    check("rd_core_d", core_d, 70'(0));
    check("rd_pad_d_rdy", 70'(pad_d_rdy), 70'(1));
    step();
    for (int k = 0; k < INB; k++) rb[k] = 10'($urandom);
    ed = '0;
    for (int k = 0; k < INB; k++) ed = ed | (70'(rb[k]) << (k * PIW));
    ez = core_fn(ed);
    for (int j = 0; j < OUTB; j++) reb[j] = 10'(ez >> (j * POW));
    run_frame(rb, 0, 1'b0, 1'b0, ed, '0, 1'b0, reb, 1'b0);

    // Randomized frames: gaps, resync junk, random output backpressure.
    for (int f = 0; f < 20; f++) begin
      for (int k = 0; k < INB; k++) rb[k] = 10'($urandom);
      ed = '0;
      for (int k = 0; k < INB; k++) ed = ed | (70'(rb[k]) << (k * PIW));
      ez = core_fn(ed);
      for (int j = 0; j < OUTB; j++) reb[j] = 10'(ez >> (j * POW));
      run_frame(rb, $urandom_range(0, 3), 1'b1, 1'b1, ed, '0, 1'b0, reb, 1'b1);
    end

    // Wider input pads, longer core latency: 5 input beats, top bits of beat 4 dropped.
    pad_d_vld1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      pad_d1     = (k == 4) ? 16'hFFC5 : 16'(16'h1111 * (k + 1));
      pad_d_sof1 = (k == 0);
      step();
    end
    pad_d_vld1 = 1'b0;
    pad_d_sof1 = 1'b0;
    check("sw_core_d_vld", 70'(core_d_vld1), 70'(1));
    check("sw_core_d", core_d1, {6'h05, 16'h4444, 16'h3333, 16'h2222, 16'h1111});
    check("sw_vld_t1", 70'(pad_z_vld1), 70'(0));
    for (int i = 2; i < 5; i++) begin
      step();
      check("sw_vld_early", 70'(pad_z_vld1), 70'(0));
    end
    step();
    check("sw_vld_t5", 70'(pad_z_vld1), 70'(1));
    check("sw_pad_z0", 70'(pad_z1), 70'(10'h3CD));
    pad_z_rdy1 = 1'b1;
    repeat (5) step();
    check("sw_done_vld", 70'(pad_z_vld1), 70'(0));
    check("sw_done_rdy", 70'(pad_d_rdy1), 70'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
